// File: rtl/pencoder_arb.sv
// Registered N-input priority encoder/arbiter with fixed or round-robin priority.
// Latency: req sampled at a rising edge appears on the outputs right after that edge.
// Backpressure: a presented grant is held stable until out_ready; accepts can run back-to-back.
module pencoder_arb #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_code,
  output logic [N-1:0] out_onehot,
  output logic         out_multi
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [W:0] N_EXT = (W+1)'(N);

  state_t         state;
  logic [W-1:0]   ptr;
  logic           accept;
  logic [W-1:0]   sel_ptr;
  logic           win_found;
  logic [W-1:0]   win_code;
  logic [N-1:0]   win_onehot;
  logic           win_multi;
  logic [W:0]     cand;

  // Pointer used for this edge's search: an accept on the same edge moves the
  // pointer to the code being retired, so back-to-back grants rotate correctly.
  // Fixed mode always searches as if ptr were 0.
  always_comb begin
    accept  = (state == HOLD) && out_ready;
    sel_ptr = '0;
    if (mode) begin
      sel_ptr = accept ? out_code : ptr;
    end
  end

  // Descending search starting at sel_ptr-1, wrapping from 0 to N-1 (not 2^W-1).
  always_comb begin
    win_found  = 1'b0;
    win_code   = '0;
    win_onehot = '0;
    cand       = '0;
    for (int i = 0; i < N; i++) begin
      // sel_ptr + N-1-i stays below 2N, so a single conditional subtract is the modulo.
      cand = {1'b0, sel_ptr} + (W+1)'(N - 1 - i);
      if (cand >= N_EXT) begin
        cand = cand - N_EXT;
      end
      if (!win_found && req[cand[W-1:0]]) begin
        win_found = 1'b1;
        win_code  = cand[W-1:0];
      end
    end
    for (int j = 0; j < N; j++) begin
      win_onehot[j] = win_found && (win_code == W'(j));
    end
    win_multi = |(req & (req - N'(1)));
  end

  // Two-state grant FSM; all outputs and the round-robin pointer are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_code   <= '0;
      out_onehot <= '0;
      out_multi  <= 1'b0;
      ptr        <= '0;
    end else begin
      ptr <= sel_ptr;
      case (state)
        IDLE: begin
          if (|req) begin
            out_valid  <= 1'b1;
            out_code   <= win_code;
            out_onehot <= win_onehot;
            out_multi  <= win_multi;
            state      <= HOLD;
          end else begin
            out_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (|req) begin
              out_code   <= win_code;
              out_onehot <= win_onehot;
              out_multi  <= win_multi;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
